// File: rtl/ram9_port_arbiter.sv
// rtl/ram9_port_arbiter.sv - two-requester arbiter for a shared 16 x 9-bit RAM with independent read/write ports.
// Optional write-first bypass for same-address read+write: define RAM9_ARB_WRITE_BYPASS_EN.
module ram9_port_arbiter #(
    parameter int PRIORITY_MODE = 0,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       A_VALID,
    input  logic       A_WE,
    input  logic [3:0] A_ADDR,
    input  logic [8:0] A_WDATA,
    output logic       A_READY,
    output logic       A_RVALID,
    output logic [8:0] A_RDATA,
    input  logic       B_VALID,
    input  logic       B_WE,
    input  logic [3:0] B_ADDR,
    input  logic [8:0] B_WDATA,
    output logic       B_READY,
    output logic       B_RVALID,
    output logic [8:0] B_RDATA,
    output logic [6:0] MEM_R_ADDR,
    input  logic [8:0] MEM_R_RD_DATA,
    output logic       MEM_W_WR_EN,
    output logic [6:0] MEM_W_ADDR,
    output logic [8:0] MEM_W_WR_DATA
);

    logic       rd_req_a, rd_req_b, wr_req_a, wr_req_b;
    logic       rd_gnt_a, rd_gnt_b, wr_gnt_a, wr_gnt_b;
    logic       rd_gnt, wr_gnt;
    logic       rd_last_b, wr_last_b;
    logic [3:0] rd_starve, wr_starve;
    logic [3:0] rd_addr_sel, wr_addr_sel, rd_addr_q;
    logic       pend, owner_b;
    logic [8:0] hold_a, hold_b, rd_data;

    // Returns {grant_b, grant_a}; only a contended cycle consults the policy.
    function automatic logic [1:0] arbitrate(input logic req_a, input logic req_b,
                                             input logic last_b, input logic [3:0] starve);
        logic b_wins;
        b_wins = req_b;
        if (req_a && req_b) begin
            if (PRIORITY_MODE == 1)
                b_wins = (starve == STARVE_LIMIT[3:0]);
            else
                b_wins = !last_b;
        end
        return {b_wins, req_a && !b_wins};
    endfunction

    assign rd_req_a = A_VALID && !A_WE && !RST;
    assign rd_req_b = B_VALID && !B_WE && !RST;
    assign wr_req_a = A_VALID &&  A_WE && !RST;
    assign wr_req_b = B_VALID &&  B_WE && !RST;

    assign {rd_gnt_b, rd_gnt_a} = arbitrate(rd_req_a, rd_req_b, rd_last_b, rd_starve);
    assign {wr_gnt_b, wr_gnt_a} = arbitrate(wr_req_a, wr_req_b, wr_last_b, wr_starve);
    assign rd_gnt = rd_gnt_a || rd_gnt_b;
    assign wr_gnt = wr_gnt_a || wr_gnt_b;

    assign A_READY = A_WE ? wr_gnt_a : rd_gnt_a;
    assign B_READY = B_WE ? wr_gnt_b : rd_gnt_b;

    assign rd_addr_sel   = rd_gnt_b ? B_ADDR : A_ADDR;
    assign wr_addr_sel   = wr_gnt_b ? B_ADDR : A_ADDR;
    assign MEM_R_ADDR    = {(rd_gnt ? rd_addr_sel : rd_addr_q), 3'b000};
    assign MEM_W_WR_EN   = wr_gnt;
    assign MEM_W_ADDR    = wr_gnt ? {wr_addr_sel, 3'b000} : 7'd0;
    assign MEM_W_WR_DATA = wr_gnt ? (wr_gnt_b ? B_WDATA : A_WDATA) : 9'd0;

`ifdef RAM9_ARB_WRITE_BYPASS_EN
    logic       byp_hit;
    logic [8:0] byp_data;

    // RAM is read-before-write, so a same-address collision is patched on the return path.
    always_ff @(posedge CLK) begin
        if (RST) begin
            byp_hit  <= 1'b0;
            byp_data <= 9'd0;
        end else begin
            byp_hit  <= rd_gnt && wr_gnt && (rd_addr_sel == wr_addr_sel);
            byp_data <= MEM_W_WR_DATA;
        end
    end

    assign rd_data = byp_hit ? byp_data : MEM_R_RD_DATA;
`else
    assign rd_data = MEM_R_RD_DATA;
`endif

    // Gating with RST drops a response that was pending when reset arrived.
    assign A_RVALID = pend && !owner_b && !RST;
    assign B_RVALID = pend &&  owner_b && !RST;
    assign A_RDATA  = A_RVALID ? rd_data : hold_a;
    assign B_RDATA  = B_RVALID ? rd_data : hold_b;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_last_b <= 1'b1;
            wr_last_b <= 1'b1;
            rd_starve <= 4'd0;
            wr_starve <= 4'd0;
            rd_addr_q <= 4'd0;
            pend      <= 1'b0;
            owner_b   <= 1'b0;
            hold_a    <= 9'd0;
            hold_b    <= 9'd0;
        end else begin
            if (rd_req_a && rd_req_b) rd_last_b <= rd_gnt_b;
            if (wr_req_a && wr_req_b) wr_last_b <= wr_gnt_b;

            if (rd_gnt_b)
                rd_starve <= 4'd0;
            else if (rd_req_a && rd_req_b)
                rd_starve <= rd_starve + 4'd1;

            if (wr_gnt_b)
                wr_starve <= 4'd0;
            else if (wr_req_a && wr_req_b)
                wr_starve <= wr_starve + 4'd1;

            if (rd_gnt) rd_addr_q <= rd_addr_sel;
            pend    <= rd_gnt;
            owner_b <= rd_gnt_b;

            if (A_RVALID) hold_a <= rd_data;
            if (B_RVALID) hold_b <= rd_data;
        end
    end

endmodule

// File: tb/tb_ram9_port_arbiter.sv
// tb/tb_ram9_port_arbiter.sv - randomized self-checking bench, round-robin and fixed-priority instances.
module tb_ram9_port_arbiter;

`ifdef RAM9_ARB_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_valid = 1'b0, a_we = 1'b0, b_valid = 1'b0, b_we = 1'b0;
    logic [3:0] a_addr = 4'd0, b_addr = 4'd0;
    logic [8:0] a_wdata = 9'd0, b_wdata = 9'd0;

    logic       a_ready[2], a_rvalid[2], b_ready[2], b_rvalid[2], mem_w_wr_en[2];
    logic [8:0] a_rdata[2], b_rdata[2], mem_w_wr_data[2], mem_r_rd_data[2];
    logic [6:0] mem_r_addr[2], mem_w_addr[2];
    logic [8:0] ram0[128], ram1[128];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // RAM stand-ins: registered read, read-before-write on collision.
    always @(posedge clk) begin
        if (mem_w_wr_en[0]) ram0[mem_w_addr[0]] <= mem_w_wr_data[0];
        if (mem_w_wr_en[1]) ram1[mem_w_addr[1]] <= mem_w_wr_data[1];
        mem_r_rd_data[0] <= ram0[mem_r_addr[0]];
        mem_r_rd_data[1] <= ram1[mem_r_addr[1]];
    end

    ram9_port_arbiter #(.PRIORITY_MODE(0), .STARVE_LIMIT(4)) dut_rr (
        .CLK(clk), .RST(rst),
        .A_VALID(a_valid), .A_WE(a_we), .A_ADDR(a_addr), .A_WDATA(a_wdata),
        .A_READY(a_ready[0]), .A_RVALID(a_rvalid[0]), .A_RDATA(a_rdata[0]),
        .B_VALID(b_valid), .B_WE(b_we), .B_ADDR(b_addr), .B_WDATA(b_wdata),
        .B_READY(b_ready[0]), .B_RVALID(b_rvalid[0]), .B_RDATA(b_rdata[0]),
        .MEM_R_ADDR(mem_r_addr[0]), .MEM_R_RD_DATA(mem_r_rd_data[0]),
        .MEM_W_WR_EN(mem_w_wr_en[0]), .MEM_W_ADDR(mem_w_addr[0]), .MEM_W_WR_DATA(mem_w_wr_data[0])
    );

    ram9_port_arbiter #(.PRIORITY_MODE(1), .STARVE_LIMIT(2)) dut_fx (
        .CLK(clk), .RST(rst),
        .A_VALID(a_valid), .A_WE(a_we), .A_ADDR(a_addr), .A_WDATA(a_wdata),
        .A_READY(a_ready[1]), .A_RVALID(a_rvalid[1]), .A_RDATA(a_rdata[1]),
        .B_VALID(b_valid), .B_WE(b_we), .B_ADDR(b_addr), .B_WDATA(b_wdata),
        .B_READY(b_ready[1]), .B_RVALID(b_rvalid[1]), .B_RDATA(b_rdata[1]),
        .MEM_R_ADDR(mem_r_addr[1]), .MEM_R_RD_DATA(mem_r_rd_data[1]),
        .MEM_W_WR_EN(mem_w_wr_en[1]), .MEM_W_ADDR(mem_w_addr[1]), .MEM_W_WR_DATA(mem_w_wr_data[1])
    );

    // Reference model state, one slot per instance (0 = round-robin, 1 = fixed, limit 2).
    bit         m_rd_last_b[2], m_wr_last_b[2], m_pend[2], m_owner_b[2];
    int         m_rd_miss[2], m_wr_miss[2];
    logic [8:0] m_pdata[2], m_hold_a[2], m_hold_b[2];
    logic [3:0] m_raddr[2];
    logic [8:0] gmem[2][16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void pick(input int d, input bit a, input bit b, input bit last_b,
                                 input int miss, output bit ga, output bit gb);
        bit b_wins;
        if (a && b) b_wins = (d == 1) ? (miss == 2) : !last_b;
        else        b_wins = b;
        gb = b_wins;
        ga = a && !b_wins;
    endfunction

    task automatic drive(input bit r, input bit av, input bit awe, input logic [3:0] aa,
                         input logic [8:0] ad, input bit bv, input bit bwe,
                         input logic [3:0] ba, input logic [8:0] bd);
        @(negedge clk);
        rst = r; a_valid = av; a_we = awe; a_addr = aa; a_wdata = ad;
        b_valid = bv; b_we = bwe; b_addr = ba; b_wdata = bd;
        #1;
    endtask

    // Checks every output of both instances against the model, advances the model, then clocks.
    task automatic advance();
        for (int d = 0; d < 2; d++) begin
            bit ar, br, aw, bw, gra, grb, gwa, gwb, eav, ebv;
            logic [3:0] ra, wa;
            logic [8:0] wd;
            ar = a_valid && !a_we && !rst;  br = b_valid && !b_we && !rst;
            aw = a_valid &&  a_we && !rst;  bw = b_valid &&  b_we && !rst;
            pick(d, ar, br, m_rd_last_b[d], m_rd_miss[d], gra, grb);
            pick(d, aw, bw, m_wr_last_b[d], m_wr_miss[d], gwa, gwb);
            ra  = gra ? a_addr : (grb ? b_addr : m_raddr[d]);
            wa  = gwb ? b_addr : a_addr;
            wd  = gwb ? b_wdata : a_wdata;
            eav = m_pend[d] && !m_owner_b[d] && !rst;
            ebv = m_pend[d] &&  m_owner_b[d] && !rst;
            chk($sformatf("a_ready%0d", d), a_ready[d], a_we ? gwa : gra);
            chk($sformatf("b_ready%0d", d), b_ready[d], b_we ? gwb : grb);
            chk($sformatf("wr_en%0d", d), mem_w_wr_en[d], gwa || gwb);
            chk($sformatf("w_addr%0d", d), mem_w_addr[d], (gwa || gwb) ? {wa, 3'b000} : 7'd0);
            chk($sformatf("w_data%0d", d), mem_w_wr_data[d], (gwa || gwb) ? wd : 9'd0);
            chk($sformatf("r_addr%0d", d), mem_r_addr[d], {ra, 3'b000});
            chk($sformatf("a_rvalid%0d", d), a_rvalid[d], eav);
            chk($sformatf("b_rvalid%0d", d), b_rvalid[d], ebv);
            chk($sformatf("a_rdata%0d", d), a_rdata[d], eav ? m_pdata[d] : m_hold_a[d]);
            chk($sformatf("b_rdata%0d", d), b_rdata[d], ebv ? m_pdata[d] : m_hold_b[d]);
            if (rst) begin
                m_rd_last_b[d] = 1; m_wr_last_b[d] = 1; m_rd_miss[d] = 0; m_wr_miss[d] = 0;
                m_pend[d] = 0; m_owner_b[d] = 0; m_hold_a[d] = 0; m_hold_b[d] = 0; m_raddr[d] = 0;
            end else begin
                if (eav) m_hold_a[d] = m_pdata[d];
                if (ebv) m_hold_b[d] = m_pdata[d];
                m_pend[d] = gra || grb;
                m_owner_b[d] = grb;
                m_raddr[d] = ra;
                m_pdata[d] = (BYPASS && (gwa || gwb) && wa == ra) ? wd : gmem[d][ra];
                if (gwa || gwb) gmem[d][wa] = wd;
                if (ar && br) m_rd_last_b[d] = grb;
                if (aw && bw) m_wr_last_b[d] = gwb;
                m_rd_miss[d] = grb ? 0 : ((ar && br) ? m_rd_miss[d] + 1 : m_rd_miss[d]);
                m_wr_miss[d] = gwb ? 0 : ((aw && bw) ? m_wr_miss[d] + 1 : m_wr_miss[d]);
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input bit r);
        drive(r, 0, 0, 4'd0, 9'd0, 0, 0, 4'd0, 9'd0);
        advance();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin ram0[i] = 9'd0; ram1[i] = 9'd0; end
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) gmem[d][i] = 9'd0;
            m_pdata[d] = 9'd0; m_hold_a[d] = 9'd0; m_hold_b[d] = 9'd0; m_raddr[d] = 4'd0;
        end
        idle(1); idle(1);

        // A writes then reads back.
        drive(0, 1, 1, 4'd3, 9'h1A5, 0, 0, 4'd0, 9'd0);
        chk("t1_wr_ready", a_ready[0], 1);
        advance();
        drive(0, 1, 0, 4'd3, 9'd0, 0, 0, 4'd0, 9'd0);
        chk("t1_rd_ready", a_ready[0], 1);
        advance();
        drive(0, 0, 0, 4'd0, 9'd0, 0, 0, 4'd0, 9'd0);
        chk("t1_rvalid", a_rvalid[0], 1);
        chk("t1_rdata", a_rdata[0], 9'h1A5);
        chk("t1_b_rvalid", b_rvalid[0], 0);
        advance();

        // Round-robin read contention alternates starting with A.
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 4'(i), 9'd0, 1, 0, 4'(i + 4), 9'd0);
            chk("t2_rr_a_ready", a_ready[0], (i % 2) == 0);
            advance();
        end
        idle(0);

        // Read and write granted together.
        drive(0, 1, 0, 4'd5, 9'd0, 1, 1, 4'd9, 9'h0FF);
        chk("t3_a_ready", a_ready[0], 1);
        chk("t3_b_ready", b_ready[0], 1);
        chk("t3_wr_en", mem_w_wr_en[0], 1);
        advance();

        // Same-address collision.
        drive(0, 1, 1, 4'd7, 9'h011, 0, 0, 4'd0, 9'd0);
        advance();
        drive(0, 1, 0, 4'd7, 9'd0, 1, 1, 4'd7, 9'h122);
        advance();
        drive(0, 0, 0, 4'd0, 9'd0, 0, 0, 4'd0, 9'd0);
        chk("t4_collide", a_rdata[0], BYPASS ? 9'h122 : 9'h011);
        advance();

        // Fixed priority with starvation limit 2: A, A, B, A, A, B.
        idle(1);
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 1, 4'd1, 9'(i), 1, 1, 4'd2, 9'(i + 32));
            chk("t5_fx_b_ready", b_ready[1], (i % 3) == 2);
            advance();
        end

        // Reset while a read is pending drops the response.
        drive(0, 1, 0, 4'd4, 9'd0, 0, 0, 4'd0, 9'd0);
        advance();
        drive(1, 1, 0, 4'd4, 9'd0, 1, 1, 4'd4, 9'd3);
        chk("t6_rst_rvalid", a_rvalid[0], 0);
        chk("t6_rst_ready", a_ready[0], 0);
        advance();
        drive(0, 0, 0, 4'd0, 9'd0, 0, 0, 4'd0, 9'd0);
        chk("t6_rdata", a_rdata[0], 0);
        chk("t6_raddr", mem_r_addr[0], 0);
        chk("t6_rvalid", a_rvalid[0], 0);
        advance();

        // Randomized traffic with occasional resets; narrow address range forces collisions.
        for (int n = 0; n < 500; n++) begin
            logic [3:0] aa, ba;
            aa = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            ba = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  aa, 9'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  ba, 9'($urandom));
            advance();
        end
        idle(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
